sram_fault_model: RTL
=====================

// Module: sram_fault_model
// PURPOSE
// Synthesizable responder for the sram_ctrl SRAM pin interface: a 1024x8 synchronous SRAM.
// Adds a programmable stuck-at fault table, access counters and a protocol-error flag.
// Sits under the controller in the sram_test bench/FPGA top so march/read-back tests detect injected faults.
// PARAMETERS
// AW       10  address width (depth = 2**AW)
// DW       8   data width
// NFAULT   4   fault-table entries
// CNTW     16  access-counter width (saturating)
// PORTS
// clk        in   1       single clock; memory samples on posedge (s_clk from controller = clk)
// reset      in   1       asynchronous, active-high; clears regs/counters/fault table, NOT memory array
// s_cen      in   1       chip enable, active low
// s_wen      in   1       write enable, active low (high = read)
// s_oen      in   1       output enable, active low
// s_addr     in   AW      access address
// s_ddata    in   DW      write data
// s_qdata    out  DW      read data
// fi_we      in   1       fault-table write strobe (one cycle)
// fi_idx     in   2       entry index (log2 NFAULT)
// fi_en      in   1       entry valid
// fi_addr    in   AW      faulty address
// fi_mask    in   DW      stuck bit mask (1 = bit stuck)
// fi_val     in   DW      stuck values for masked bits
// cnt_clr    in   1       sync clear of counters and proto_err
// wr_cnt     out  CNTW    accepted writes
// rd_cnt     out  CNTW    accepted reads
// proto_err  out  1       sticky: cen=0 & wen=0 & oen=0 seen
// BEHAVIOUR
// Reset values: s_qdata=0, q_reg=0, wr_cnt=0, rd_cnt=0, proto_err=0, all fault entries invalid.
// Memory array has no reset; contents survive reset (sim starts X).
// Write: posedge with cen=0, wen=0 -> mem[addr] <= fault(addr, ddata). Zero latency.
// Read: posedge with cen=0, wen=1 -> q_reg <= fault(addr, mem[addr]); 1-cycle latency from sampled addr.
// Output: s_qdata = (oen==0) ? q_reg : 0; combinational on oen only; q_reg holds when no read.
// cen=1: no access, q_reg holds, counters hold; wen/oen ignored.
// fault(a,d): for every valid entry with fi_addr==a, d = (d & ~mask) | (val & mask);
//   multiple matching entries applied in index order 0..NFAULT-1 (higher index wins per bit).
// Read-after-write same addr: write at cycle N, read at N+1 returns new data at N+2.
// Fault-table update: registered on fi_we; takes effect for accesses from the next posedge.
//   fi_we coincident with an access: access uses old table.
// Counters: +1 per accepted write/read; saturate at all-ones, no wrap.
// cnt_clr has priority over increment in the same cycle (result 0).
// proto_err: set when cen=0, wen=0, oen=0 at posedge; the write still occurs, s_qdata forced 0 while
//   wen=0 & oen=0; cleared only by reset or cnt_clr (set wins if both same cycle).
// Address out of range impossible (AW bits = full depth).
// Reset mid-access: q_reg and s_qdata go to 0 immediately; an in-flight write at the reset edge is not performed.
// STRUCTURE
// sram_defs.vh: ENA=1'b0, DISENA=1'b1, SRAM_AW=10, SRAM_DW=8 shared with sram_ctrl.
// Sub-module sram_fault_table: NFAULT entry regs + combinational apply(addr,data); instanced once,
//   used on both write and read paths (two apply ports). Top holds array, q_reg, counters, proto_err.
// TESTING
// Fill 0..1023 with addr[7:0], read back -> every read = addr[7:0], wr_cnt=1024, rd_cnt=1024.
// Entry0 addr=0x155 mask=0x81 val=0x01; write 0xFF then read 0x155 -> 0x7F; read 0x154 unaffected.
// Entries 0,1 both addr=0x010, masks 0x0F/0x03 vals 0x00/0x03; write 0xAA -> read 0xA3.
// cen=0 wen=0 oen=0 at addr 5, data 0x3C -> proto_err=1, s_qdata=0; later read 5 -> 0x3C.
// Pulse reset after writing 0x5A to addr 7 -> counters 0, s_qdata 0; read addr 7 -> 0x5A.
// Force rd_cnt near 0xFFFF (65536 reads) -> holds 0xFFFF; cnt_clr with read same cycle -> 0.

Source files
------------

// File: rtl/sram_fault_model_pkg.sv
// Shared SRAM pin-interface constants and default geometry for the fault-injecting SRAM model.
package sram_fault_model_pkg;
    localparam logic ENA         = 1'b0;
    localparam logic DISENA      = 1'b1;
    localparam int   SRAM_AW     = 10;
    localparam int   SRAM_DW     = 8;
    localparam int   SRAM_NFAULT = 4;
    localparam int   SRAM_CNTW   = 16;
endpackage

// File: rtl/sram_fault_model_fault_table.sv
// Programmable stuck-at fault table; two independent combinational apply ports (write path, read path).
// Entries update on fi_we and affect accesses from the following edge onward.
module sram_fault_table #(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int NFAULT = 4,
    parameter int IW     = $clog2(NFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fi_we,
    input  logic [IW-1:0] fi_idx,
    input  logic          fi_en,
    input  logic [AW-1:0] fi_addr,
    input  logic [DW-1:0] fi_mask,
    input  logic [DW-1:0] fi_val,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    input  logic [DW-1:0] i_rd_data,
    output logic [DW-1:0] o_rd_data
);
    logic          r_en   [NFAULT];
    logic [AW-1:0] r_addr [NFAULT];
    logic [DW-1:0] r_mask [NFAULT];
    logic [DW-1:0] r_val  [NFAULT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NFAULT; i++) begin
                r_en[i]   <= 1'b0;
                r_addr[i] <= '0;
                r_mask[i] <= '0;
                r_val[i]  <= '0;
            end
        end else if (fi_we) begin
            r_en[fi_idx]   <= fi_en;
            r_addr[fi_idx] <= fi_addr;
            r_mask[fi_idx] <= fi_mask;
            r_val[fi_idx]  <= fi_val;
        end
    end

    // Ascending index order so a higher entry overrides a lower one bit by bit.
    always_comb begin
        o_wr_data = i_wr_data;
        o_rd_data = i_rd_data;
        for (int i = 0; i < NFAULT; i++) begin
            if (r_en[i] && (r_addr[i] == i_wr_addr))
                o_wr_data = (o_wr_data & ~r_mask[i]) | (r_val[i] & r_mask[i]);
            if (r_en[i] && (r_addr[i] == i_rd_addr))
                o_rd_data = (o_rd_data & ~r_mask[i]) | (r_val[i] & r_mask[i]);
        end
    end
endmodule

// File: rtl/sram_fault_model.sv
// 1024x8 synchronous SRAM responder with stuck-at fault injection, saturating access counters
// and a sticky protocol-error flag. Array is not reset; everything else is.
module sram_fault_model
    import sram_fault_model_pkg::*;
#(
    parameter int AW     = SRAM_AW,
    parameter int DW     = SRAM_DW,
    parameter int NFAULT = SRAM_NFAULT,
    parameter int CNTW   = SRAM_CNTW,
    parameter int IW     = $clog2(NFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_cen,
    input  logic            s_wen,
    input  logic            s_oen,
    input  logic [AW-1:0]   s_addr,
    input  logic [DW-1:0]   s_ddata,
    output logic [DW-1:0]   s_qdata,
    input  logic            fi_we,
    input  logic [IW-1:0]   fi_idx,
    input  logic            fi_en,
    input  logic [AW-1:0]   fi_addr,
    input  logic [DW-1:0]   fi_mask,
    input  logic [DW-1:0]   fi_val,
    input  logic            cnt_clr,
    output logic [CNTW-1:0] wr_cnt,
    output logic [CNTW-1:0] rd_cnt,
    output logic            proto_err
);
    logic [DW-1:0]   r_mem [0:(2**AW)-1];
    logic [DW-1:0]   r_q;
    logic [CNTW-1:0] r_wr_cnt;
    logic [CNTW-1:0] r_rd_cnt;
    logic            r_proto_err;

    logic            w_wr;
    logic            w_rd;
    logic            w_proto;
    logic [DW-1:0]   w_wr_data;
    logic [DW-1:0]   w_rd_data;

    assign w_wr    = (s_cen == ENA) && (s_wen == ENA);
    assign w_rd    = (s_cen == ENA) && (s_wen == DISENA);
    assign w_proto = w_wr && (s_oen == ENA);

    sram_fault_table #(.AW(AW), .DW(DW), .NFAULT(NFAULT), .IW(IW)) u_fault_table (
        .clk       (clk),
        .reset     (reset),
        .fi_we     (fi_we),
        .fi_idx    (fi_idx),
        .fi_en     (fi_en),
        .fi_addr   (fi_addr),
        .fi_mask   (fi_mask),
        .fi_val    (fi_val),
        .i_wr_addr (s_addr),
        .i_wr_data (s_ddata),
        .o_wr_data (w_wr_data),
        .i_rd_addr (s_addr),
        .i_rd_data (r_mem[s_addr]),
        .o_rd_data (w_rd_data)
    );

    // No reset on the array: contents must survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_wr)
            r_mem[s_addr] <= w_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q         <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_rd)
                r_q <= w_rd_data;

            if (cnt_clr)
                r_wr_cnt <= '0;
            else if (w_wr && (r_wr_cnt != '1))
                r_wr_cnt <= r_wr_cnt + 1'b1;

            if (cnt_clr)
                r_rd_cnt <= '0;
            else if (w_rd && (r_rd_cnt != '1))
                r_rd_cnt <= r_rd_cnt + 1'b1;

            if (w_proto)
                r_proto_err <= 1'b1;
            else if (cnt_clr)
                r_proto_err <= 1'b0;
        end
    end

    // Bus is driven only with oen low and never while a write is being presented.
    assign s_qdata   = ((s_oen == ENA) && (s_wen == DISENA)) ? r_q : '0;
    assign wr_cnt    = r_wr_cnt;
    assign rd_cnt    = r_rd_cnt;
    assign proto_err = r_proto_err;
endmodule
